csr_wb_seq: RTL and testbench

- Write-side sequencer for the machine-mode CSR file.
- Sits in WBU. Accepts one retired CSR/ecall/mret instruction per handshake.
- The CSR file has a single write port, so this block serialises the required writes (csrrw/rs/rc, ecall trap entry, mret return) onto that port, one per cycle.
- Emits the rd writeback value and the redirect PC for ecall/mret.

---
 rtl/csr_pkg.sv | 48 ++++
 rtl/csr_alu.sv | 36 +++
 rtl/csr_wb_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_csr_wb_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR write-back sequencer.
// CSR_MSTATUS_UPDATE_EN adds the STATUS state used for mstatus updates on ecall/mret.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam int unsigned MS_MIE    = 3;
  localparam int unsigned MS_MPIE   = 7;
  localparam int unsigned MS_MPP_LO = 11;
  localparam int unsigned MS_MPP_HI = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_EPC,
`ifdef CSR_MSTATUS_UPDATE_EN
    S_CAUSE,
    S_STATUS
`else
    S_CAUSE
`endif
  } state_t;

  typedef enum logic [1:0] {
    K_NONE,
    K_CSR,
    K_ECALL,
    K_MRET
  } kind_t;

  function automatic logic is_csr_op(input logic [2:0] f3);
    return (f3 == F3_RW)  || (f3 == F3_RS)  || (f3 == F3_RC) ||
           (f3 == F3_RWI) || (f3 == F3_RSI) || (f3 == F3_RCI);
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational new-value compute for csrrw/rs/rc and their immediate forms.
module csr_alu
  import csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] old,
  input  logic [DATA_WIDTH-1:0] src,
  input  logic                  src_zero,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  write_needed
);

  always_comb begin
    wdata        = old;
    write_needed = 1'b0;
    case (op)
      F3_RW, F3_RWI: begin
        wdata        = src;
        write_needed = 1'b1;
      end
      // set/clear with a zero source must not touch the CSR at all
      F3_RS, F3_RSI: begin
        wdata        = old | src;
        write_needed = !src_zero;
      end
      F3_RC, F3_RCI: begin
        wdata        = old & ~src;
        write_needed = !src_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_wb_seq.sv
// Serialises retired CSR/ecall/mret writes onto the single CSR write port.
// CSR_MSTATUS_UPDATE_EN enables the mstatus write on ecall and mret.
module csr_wb_seq
  import csr_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH  = 12,
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] ECALL_CAUSE = 'hb
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic                  in_is_ecall,
  input  logic                  in_is_mret,
  input  logic [ADDR_WIDTH-1:0] in_csr_addr,
  input  logic [DATA_WIDTH-1:0] in_src,
  input  logic                  in_src_zero,
  input  logic [DATA_WIDTH-1:0] in_csr_old,
  input  logic [DATA_WIDTH-1:0] in_mstatus,
  input  logic [DATA_WIDTH-1:0] in_mtvec,
  input  logic [DATA_WIDTH-1:0] in_mepc,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  csr_wen,
  output logic [ADDR_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  rd_wen,
  output logic [DATA_WIDTH-1:0] rd_wdata,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  done
);

  state_t state, state_n;
  kind_t  kind_q, kind_n;

  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] src_q, old_q, mtvec_q, mepc_q, pc_q;
  logic                  src_zero_q;

  logic [DATA_WIDTH-1:0] alu_wdata;
  logic                  alu_write;

  logic                  csr_wen_n, rd_wen_n, redirect_valid_n, done_n;
  logic [ADDR_WIDTH-1:0] csr_waddr_n;
  logic [DATA_WIDTH-1:0] csr_wdata_n, rd_wdata_n, redirect_pc_n;

  logic accept;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid & in_ready;

`ifdef CSR_MSTATUS_UPDATE_EN
  logic [DATA_WIDTH-1:0] mstatus_q, ecall_status, mret_status;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        mstatus_q <= '0;
    else if (accept) mstatus_q <= in_mstatus;
  end

  always_comb begin
    ecall_status                        = mstatus_q;
    ecall_status[MS_MPIE]               = mstatus_q[MS_MIE];
    ecall_status[MS_MIE]                = 1'b0;
    ecall_status[MS_MPP_HI:MS_MPP_LO]   = 2'b11;
    mret_status                         = mstatus_q;
    mret_status[MS_MIE]                 = mstatus_q[MS_MPIE];
    mret_status[MS_MPIE]                = 1'b1;
    mret_status[MS_MPP_HI:MS_MPP_LO]    = 2'b11;
  end
`else
  logic unused_mstatus;
  assign unused_mstatus = ^in_mstatus;
`endif

  csr_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .op           (op_q),
    .old          (old_q),
    .src          (src_q),
    .src_zero     (src_zero_q),
    .wdata        (alu_wdata),
    .write_needed (alu_write)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      old_q      <= '0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      pc_q       <= '0;
    end else if (accept) begin
      op_q       <= in_op;
      addr_q     <= in_csr_addr;
      src_q      <= in_src;
      src_zero_q <= in_src_zero;
      old_q      <= in_csr_old;
      mtvec_q    <= in_mtvec;
      mepc_q     <= in_mepc;
      pc_q       <= in_pc;
    end
  end

  // Outputs are computed one state ahead and registered, so each state's
  // effect appears on the edge that leaves it.
  always_comb begin
    state_n          = state;
    kind_n           = kind_q;
    csr_wen_n        = 1'b0;
    csr_waddr_n      = csr_waddr;
    csr_wdata_n      = csr_wdata;
    rd_wen_n         = 1'b0;
    rd_wdata_n       = rd_wdata;
    redirect_valid_n = 1'b0;
    redirect_pc_n    = redirect_pc;
    done_n           = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_is_ecall) begin
            kind_n  = K_ECALL;
            state_n = S_EPC;
          end else if (in_is_mret) begin
            kind_n  = K_MRET;
`ifdef CSR_MSTATUS_UPDATE_EN
            state_n = S_STATUS;
`else
            state_n = S_WR;
`endif
          end else if (is_csr_op(in_op)) begin
            kind_n  = K_CSR;
            state_n = S_WR;
          end else begin
            kind_n  = K_NONE;
            state_n = S_WR;
          end
        end
      end

      S_WR: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
        case (kind_q)
          K_CSR: begin
            rd_wen_n   = 1'b1;
            rd_wdata_n = old_q;
            if (alu_write) begin
              csr_wen_n   = 1'b1;
              csr_waddr_n = addr_q;
              csr_wdata_n = alu_wdata;
            end
          end
          K_MRET: begin
            redirect_valid_n = 1'b1;
            redirect_pc_n    = mepc_q;
          end
          default: ;
        endcase
      end

      S_EPC: begin
        csr_wen_n   = 1'b1;
        csr_waddr_n = ADDR_WIDTH'(CSR_MEPC);
        csr_wdata_n = pc_q;
        state_n     = S_CAUSE;
      end

      S_CAUSE: begin
        csr_wen_n   = 1'b1;
        csr_waddr_n = ADDR_WIDTH'(CSR_MCAUSE);
        csr_wdata_n = ECALL_CAUSE;
`ifdef CSR_MSTATUS_UPDATE_EN
        state_n     = S_STATUS;
`else
        done_n           = 1'b1;
        redirect_valid_n = 1'b1;
        redirect_pc_n    = mtvec_q;
        state_n          = S_IDLE;
`endif
      end

`ifdef CSR_MSTATUS_UPDATE_EN
      S_STATUS: begin
        csr_wen_n        = 1'b1;
        csr_waddr_n      = ADDR_WIDTH'(CSR_MSTATUS);
        done_n           = 1'b1;
        redirect_valid_n = 1'b1;
        state_n          = S_IDLE;
        if (kind_q == K_ECALL) begin
          csr_wdata_n   = ecall_status;
          redirect_pc_n = mtvec_q;
        end else begin
          csr_wdata_n   = mret_status;
          redirect_pc_n = mepc_q;
        end
      end
`endif

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      kind_q         <= K_NONE;
      csr_wen        <= 1'b0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      rd_wen         <= 1'b0;
      rd_wdata       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      kind_q         <= kind_n;
      csr_wen        <= csr_wen_n;
      csr_waddr      <= csr_waddr_n;
      csr_wdata      <= csr_wdata_n;
      rd_wen         <= rd_wen_n;
      rd_wdata       <= rd_wdata_n;
      redirect_valid <= redirect_valid_n;
      redirect_pc    <= redirect_pc_n;
      done           <= done_n;
    end
  end

endmodule

// File: tb/tb_csr_wb_seq.sv
// Directed scoreboard bench for csr_wb_seq; follows CSR_MSTATUS_UPDATE_EN like the RTL.
module tb_csr_wb_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic        in_is_ecall = 1'b0;
  logic        in_is_mret = 1'b0;
  logic [11:0] in_csr_addr = '0;
  logic [31:0] in_src = '0;
  logic        in_src_zero = 1'b0;
  logic [31:0] in_csr_old = '0;
  logic [31:0] in_mstatus = '0;
  logic [31:0] in_mtvec = '0;
  logic [31:0] in_mepc = '0;
  logic [31:0] in_pc = '0;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        rd_wen;
  logic [31:0] rd_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        done;

  csr_wb_seq #(
    .ADDR_WIDTH  (12),
    .DATA_WIDTH  (32),
    .ECALL_CAUSE (32'hb)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_is_ecall    (in_is_ecall),
    .in_is_mret     (in_is_mret),
    .in_csr_addr    (in_csr_addr),
    .in_src         (in_src),
    .in_src_zero    (in_src_zero),
    .in_csr_old     (in_csr_old),
    .in_mstatus     (in_mstatus),
    .in_mtvec       (in_mtvec),
    .in_mepc        (in_mepc),
    .in_pc          (in_pc),
    .csr_wen        (csr_wen),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .rd_wen         (rd_wen),
    .rd_wdata       (rd_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [11:0] wa;
    logic [31:0] wd;
    logic        rdw;
    logic [31:0] rdd;
    logic        rv;
    logic [31:0] rpc;
    logic        dn;
  } rec_t;

  rec_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [11:0] h_wa = '0;
  logic [31:0] h_wd = '0, h_rdd = '0, h_rpc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Held-value model: address/data registers only move when their strobe fires.
  task automatic push(input logic wen, input logic [11:0] wa, input logic [31:0] wd,
                      input logic rdw, input logic [31:0] rdd,
                      input logic rv, input logic [31:0] rpc, input logic dn);
    rec_t r;
    if (wen) begin h_wa = wa; h_wd = wd; end
    if (rdw) h_rdd = rdd;
    if (rv)  h_rpc = rpc;
    r = '{wen, h_wa, h_wd, rdw, h_rdd, rv, h_rpc, dn};
    q.push_back(r);
  endtask

  task automatic push_idle();
    push(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic cmp(input string tag, input rec_t r);
    chk({tag, ".csr_wen"},   32'(csr_wen),        32'(r.wen));
    chk({tag, ".csr_waddr"}, 32'(csr_waddr),      32'(r.wa));
    chk({tag, ".csr_wdata"}, csr_wdata,           r.wd);
    chk({tag, ".rd_wen"},    32'(rd_wen),         32'(r.rdw));
    chk({tag, ".rd_wdata"},  rd_wdata,            r.rdd);
    chk({tag, ".redir_v"},   32'(redirect_valid), 32'(r.rv));
    chk({tag, ".redir_pc"},  redirect_pc,         r.rpc);
    chk({tag, ".done"},      32'(done),           32'(r.dn));
  endtask

  task automatic drive(input logic [2:0] op, input logic ec, input logic mr,
                       input logic [11:0] addr, input logic [31:0] src, input logic sz,
                       input logic [31:0] old, input logic [31:0] ms,
                       input logic [31:0] tvec, input logic [31:0] epc, input logic [31:0] pc);
    in_op = op; in_is_ecall = ec; in_is_mret = mr; in_csr_addr = addr;
    in_src = src; in_src_zero = sz; in_csr_old = old; in_mstatus = ms;
    in_mtvec = tvec; in_mepc = epc; in_pc = pc; in_valid = 1'b1;
  endtask

  // Accept, then keep in_valid high with a garbage ecall bundle until done
  // to show the bundle is latched and busy-time valids are ignored.
  task automatic run(input string tag);
    rec_t r;
    chk({tag, ".ready_pre"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk({tag, ".ready_busy"}, 32'(in_ready), 32'd0);
    in_is_ecall = 1'b1; in_is_mret = 1'b1; in_op = 3'b001;
    in_csr_addr = 12'(($urandom));
    in_src = $urandom; in_csr_old = $urandom; in_mstatus = $urandom;
    in_mtvec = $urandom; in_mepc = $urandom; in_pc = $urandom;
    for (int i = 0; i < 8 && q.size() > 0; i++) begin
      @(posedge clk); #1;
      r = q.pop_front();
      cmp(tag, r);
      if (r.dn) begin
        in_valid = 1'b0;
        chk({tag, ".ready_done"}, 32'(in_ready), 32'd1);
      end
    end
    chk({tag, ".queue_drained"}, 32'(q.size()), 32'd0);
    in_valid = 1'b0;
    q.delete();
  endtask

  function automatic logic [31:0] ecall_ms(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | 32'h0000_1800 | (32'(ms[3]) << 7);
  endfunction

  function automatic logic [31:0] mret_ms(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | 32'h0000_1880 | (32'(ms[7]) << 3);
  endfunction

  task automatic expect_ecall(input logic [31:0] pc, input logic [31:0] ms, input logic [31:0] tvec);
    push(1'b1, 12'h341, pc, 1'b0, '0, 1'b0, '0, 1'b0);
`ifdef CSR_MSTATUS_UPDATE_EN
    push(1'b1, 12'h342, 32'hb, 1'b0, '0, 1'b0, '0, 1'b0);
    push(1'b1, 12'h300, ecall_ms(ms), 1'b0, '0, 1'b1, tvec, 1'b1);
`else
    push(1'b1, 12'h342, 32'hb, 1'b0, '0, 1'b1, tvec, 1'b1);
    if (ms == 32'hffff_ffff) h_wd = h_wd;
`endif
    push_idle();
  endtask

  task automatic expect_mret(input logic [31:0] ms, input logic [31:0] epc);
`ifdef CSR_MSTATUS_UPDATE_EN
    push(1'b1, 12'h300, mret_ms(ms), 1'b0, '0, 1'b1, epc, 1'b1);
`else
    push(1'b0, '0, '0, 1'b0, '0, 1'b1, epc, 1'b1);
    if (ms == 32'hffff_ffff) h_wd = h_wd;
`endif
    push_idle();
  endtask

  task automatic expect_csr(input logic wen, input logic [11:0] wa, input logic [31:0] wd,
                            input logic [31:0] old);
    push(wen, wa, wd, 1'b1, old, 1'b0, '0, 1'b1);
    push_idle();
  endtask

  initial begin
    rec_t z;
    z = '{1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    cmp("reset_hold", z);
    chk("reset_hold.ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    cmp("reset_rel", z);

    drive(3'b001, 0, 0, 12'h305, 32'h8000_0100, 0, 32'h0, 0, 0, 0, 0);
    expect_csr(1'b1, 12'h305, 32'h8000_0100, 32'h0);
    run("csrrw");

    drive(3'b010, 0, 0, 12'h300, 32'h8, 0, 32'h1800, 0, 0, 0, 0);
    expect_csr(1'b1, 12'h300, 32'h1808, 32'h1800);
    run("csrrs");

    drive(3'b010, 0, 0, 12'h300, 32'h0, 1, 32'h1800, 0, 0, 0, 0);
    expect_csr(1'b0, '0, '0, 32'h1800);
    run("csrrs_zero");

    drive(3'b011, 0, 0, 12'h304, 32'h0000_00f0, 0, 32'h0000_0fff, 0, 0, 0, 0);
    expect_csr(1'b1, 12'h304, 32'h0000_0f0f, 32'h0000_0fff);
    run("csrrc");

    drive(3'b101, 0, 0, 12'h340, 32'h0, 1, 32'hdead_beef, 0, 0, 0, 0);
    expect_csr(1'b1, 12'h340, 32'h0, 32'hdead_beef);
    run("csrrwi_zero");

    drive(3'b111, 0, 0, 12'h344, 32'h0, 1, 32'h0000_0aaa, 0, 0, 0, 0);
    expect_csr(1'b0, '0, '0, 32'h0000_0aaa);
    run("csrrci_zero");

    drive(3'b110, 0, 0, 12'h344, 32'h1f, 0, 32'h0000_0100, 0, 0, 0, 0);
    expect_csr(1'b1, 12'h344, 32'h0000_011f, 32'h0000_0100);
    run("csrrsi");

    drive(3'b001, 1, 0, 12'h123, 32'h55, 0, 32'h77, 32'h1888, 32'h8000_0200, 32'h0, 32'h8000_0040);
    expect_ecall(32'h8000_0040, 32'h1888, 32'h8000_0200);
    run("ecall");

    drive(3'b000, 0, 1, 12'h0, 0, 0, 0, 32'h1880, 0, 32'h8000_0044, 0);
    expect_mret(32'h1880, 32'h8000_0044);
    run("mret");

    drive(3'b000, 1, 1, 12'h0, 0, 0, 0, 32'h0000_0008, 32'h8000_0300, 32'h8000_0500, 32'h8000_0080);
    expect_ecall(32'h8000_0080, 32'h0000_0008, 32'h8000_0300);
    run("ecall_and_mret");

    drive(3'b100, 0, 0, 12'h305, 32'h1, 0, 32'h2, 0, 0, 0, 0);
    push(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    push_idle();
    run("no_op");

    // Reset lands after the CAUSE write; no further strobe may follow it.
    drive(3'b000, 1, 0, 12'h0, 0, 0, 0, 32'h1888, 32'h8000_0600, 0, 32'h8000_00c0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    push(1'b1, 12'h341, 32'h8000_00c0, 1'b0, '0, 1'b0, '0, 1'b0);
`ifdef CSR_MSTATUS_UPDATE_EN
    push(1'b1, 12'h342, 32'hb, 1'b0, '0, 1'b0, '0, 1'b0);
`else
    push(1'b1, 12'h342, 32'hb, 1'b0, '0, 1'b1, 32'h8000_0600, 1'b1);
`endif
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      cmp("rst_mid_pre", q.pop_front());
    end
    rst = 1'b0;
    #1;
    cmp("rst_mid_now", z);
    chk("rst_mid_now.ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmp("rst_mid_hold", z);
    end
    rst = 1'b1;
    h_wa = '0; h_wd = '0; h_rdd = '0; h_rpc = '0;
    @(posedge clk); #1;
    cmp("rst_mid_rel", z);

    drive(3'b000, 1, 0, 12'h0, 0, 0, 0, 32'h0000_0080, 32'h8000_0700, 0, 32'h8000_0100);
    expect_ecall(32'h8000_0100, 32'h0000_0080, 32'h8000_0700);
    run("ecall_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
